// File: rtl/logic_ops_pkg.sv
// Shared helpers for the logical-condition monitor: the bit-condition match
// function and the saturation value used by the counters.
package logic_ops_pkg;

    // Widest operand / counter the helpers below support.
    localparam int MAX_W = 64;

    // All-ones value of a w-bit counter (w clipped to MAX_W).
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(w)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Condition match on zero-extended operands.
    // Bits above the real operand width carry zero masks, so they never
    // affect eq_ok or ne_ok.
    function automatic logic cond_match(input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input logic [MAX_W-1:0] eq_mask,
                                        input logic [MAX_W-1:0] ne_mask,
                                        input logic             zero_en);
        logic [MAX_W-1:0] x;
        logic             eq_ok;
        logic             ne_ok;
        x     = a ^ b;
        eq_ok = &(~x | ~eq_mask);
        ne_ok = &(x | ~ne_mask);
        return (eq_ok && ne_ok) || (zero_en && (a == '0));
    endfunction

endpackage

// File: rtl/logic_cond_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import logic_ops_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over increment; increment stops at SAT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != SAT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/logic_cond_monitor.sv
// Registered logical-operator checker: per valid beat reports logical
// AND/OR/equality of two operands plus a masked bit-condition match,
// counts matches, tracks the current run of consecutive matches and
// raises a sticky alarm once the run reaches RUN_TH.
module logic_cond_monitor
    import logic_ops_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int RUN_TH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] eq_mask,
    input  logic [WIDTH-1:0] ne_mask,
    input  logic             zero_en,
    input  logic             clear,
    output logic             out_valid,
    output logic             land,
    output logic             lor,
    output logic             leq,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] run_len,
    output logic             alarm
);

    // run_len value just before the beat that reaches RUN_TH.
    localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_TH - 1);

    logic m;
    logic beat_hit;
    logic beat_miss;

    logic out_valid_q, out_valid_d;
    logic land_q, land_d;
    logic lor_q, lor_d;
    logic leq_q, leq_d;
    logic hit_q, hit_d;
    logic alarm_q, alarm_d;

    // Condition match and beat qualification.
    always_comb begin
        m         = cond_match(MAX_W'(a), MAX_W'(b), MAX_W'(eq_mask),
                               MAX_W'(ne_mask), zero_en);
        beat_hit  = in_valid && m;
        beat_miss = in_valid && !m;
    end

    // Beat datapath: all flags drop to 0 on idle cycles.
    always_comb begin
        out_valid_d = in_valid;
        land_d      = in_valid && (a != '0) && (b != '0);
        lor_d       = in_valid && ((a != '0) || (b != '0));
        leq_d       = in_valid && (a == b);
        hit_d       = beat_hit;
    end

    // Sticky alarm: set on the hit that moves run_len from RUN_TH-1 to
    // RUN_TH; a run continuing past RUN_TH finds alarm already set.
    always_comb begin
        alarm_d = alarm_q;
        if (clear) begin
            alarm_d = 1'b0;
        end else if (beat_hit && (run_len == RUN_PRE)) begin
            alarm_d = 1'b1;
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            land_q      <= 1'b0;
            lor_q       <= 1'b0;
            leq_q       <= 1'b0;
            hit_q       <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            land_q      <= land_d;
            lor_q       <= lor_d;
            leq_q       <= leq_d;
            hit_q       <= hit_d;
            alarm_q     <= alarm_d;
        end
    end

    // Total hit count; clear suppresses a coinciding hit.
    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (beat_hit),
        .clr   (clear),
        .count (hit_count)
    );

    // Consecutive-hit run; idle beats leave it untouched, a miss restarts it.
    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (beat_hit),
        .clr   (clear || beat_miss),
        .count (run_len)
    );

    assign out_valid = out_valid_q;
    assign land      = land_q;
    assign lor       = lor_q;
    assign leq       = leq_q;
    assign hit       = hit_q;
    assign alarm     = alarm_q;

endmodule
